// File: rtl/joy_keymap.sv
// Joystick-to-keyboard mapper: scans button levels, queues make/break codes for
// emulated key presses, and merges them with a pass-through PS/2 key stream.
module joy_keymap_af #(
    parameter int AF_HALF = 250000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic fire,
    output logic phase
);
    localparam int CW = $clog2(AF_HALF);

    logic [CW-1:0] cnt;

    // Phase parks at 1 while idle so every fresh press reports a make first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            phase <= 1'b1;
        end else if (!en || !fire) begin
            cnt   <= '0;
            phase <= 1'b1;
        end else if (cnt == CW'(AF_HALF - 1)) begin
            cnt   <= '0;
            phase <= ~phase;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end
endmodule

module joy_keymap #(
    parameter int NUM_JOY    = 2,
    parameter int NUM_BTN    = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int AF_HALF    = 250000
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [NUM_JOY*NUM_BTN-1:0] joy_in,
    input  logic [2*NUM_JOY-1:0]       cfg_mode,
    input  logic [NUM_JOY-1:0]         autofire_en,
    input  logic [10:0]                ps2_key,
    output logic                       key_strobe,
    output logic                       key_press,
    output logic [8:0]                 key_code,
    output logic                       queue_full
);
    localparam int NB    = NUM_JOY * NUM_BTN;
    localparam int IW    = $clog2(NB);
    localparam int BW    = $clog2(NUM_BTN);
    localparam int CHW   = (NUM_JOY > 1) ? $clog2(NUM_JOY) : 1;
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int FIRE1 = (NUM_BTN > 4) ? 4 : 0;
    localparam logic [AW:0] FULL_OCC = (AW+1)'(FIFO_DEPTH);

    // Async assert, clock-aligned release for everything downstream.
    logic [1:0] rst_sync;
    logic       rst_n;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) rst_sync <= 2'b00;
        else          rst_sync <= {rst_sync[0], 1'b1};
    end
    assign rst_n = rst_sync[1];

    logic [NUM_JOY-1:0] af_phase;

    for (genvar j = 0; j < NUM_JOY; j++) begin : g_af
        joy_keymap_af #(.AF_HALF(AF_HALF)) u_af (
            .clk   (clk),
            .rst_n (rst_n),
            .en    (autofire_en[j]),
            .fire  (joy_in[j*NUM_BTN + FIRE1] & (NUM_BTN > 4)),
            .phase (af_phase[j])
        );
    end

    logic [NB-1:0] eff;

    always_comb begin
        eff = joy_in;
        for (int j = 0; j < NUM_JOY; j++)
            if (NUM_BTN > 4 && autofire_en[j] && !af_phase[j])
                eff[j*NUM_BTN + FIRE1] = 1'b0;
    end

    function automatic logic [8:0] key_of(input logic [1:0] mode, input logic [2:0] btn);
        logic [8:0] k;
        k = 9'h000;
        case (mode)
            2'd1: case (btn)
                3'd0: k = 9'h03D; 3'd1: k = 9'h036; 3'd2: k = 9'h03E; 3'd3: k = 9'h046;
                3'd4: k = 9'h045; 3'd5: k = 9'h03A; 3'd6: k = 9'h031; default: k = 9'h032;
            endcase
            2'd2: case (btn)
                3'd0: k = 9'h01E; 3'd1: k = 9'h016; 3'd2: k = 9'h026; 3'd3: k = 9'h025;
                3'd4: k = 9'h02E; 3'd5: k = 9'h01A; 3'd6: k = 9'h022; default: k = 9'h021;
            endcase
            2'd3: case (btn)
                3'd0: k = 9'h174; 3'd1: k = 9'h16B; 3'd2: k = 9'h172; 3'd3: k = 9'h175;
                3'd4: k = 9'h05A; 3'd5: k = 9'h00D; 3'd6: k = 9'h029; default: k = 9'h076;
            endcase
            default: k = 9'h000;
        endcase
        return k;
    endfunction

    logic [IW-1:0]  idx;
    logic [BW-1:0]  btn;
    logic [CHW-1:0] ch;
    logic [NB-1:0]  joy_r;
    logic [9:0]     mem [FIFO_DEPTH];
    logic [AW:0]    wr_ptr, rd_ptr, occ;
    logic [1:0]     cur_mode;
    logic           change, empty, push, upd;

    assign occ        = wr_ptr - rd_ptr;
    assign empty      = (wr_ptr == rd_ptr);
    assign queue_full = (occ == FULL_OCC);
    assign cur_mode   = cfg_mode[{ch, 1'b0} +: 2];
    assign change     = (eff[idx] != joy_r[idx]);
    assign push       = change && (cur_mode != 2'd0) && !queue_full;
    // A blocked change leaves joy_r alone so the next visit retries it.
    assign upd        = change && ((cur_mode == 2'd0) || !queue_full);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx    <= '0;
            btn    <= '0;
            ch     <= '0;
            joy_r  <= '0;
            wr_ptr <= '0;
        end else begin
            if (idx == IW'(NB - 1)) begin
                idx <= '0;
                btn <= '0;
                ch  <= '0;
            end else begin
                idx <= idx + 1'b1;
                if (btn == BW'(NUM_BTN - 1)) begin
                    btn <= '0;
                    ch  <= ch + 1'b1;
                end else begin
                    btn <= btn + 1'b1;
                end
            end
            if (upd)  joy_r[idx] <= eff[idx];
            if (push) wr_ptr     <= wr_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= {eff[idx], key_of(cur_mode, 3'(btn))};
    end

    logic ps2_copy, ps2_armed, ps2_evt;

    assign ps2_evt = ps2_armed && (ps2_key[10] != ps2_copy);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ps2_armed <= 1'b0;
            ps2_copy  <= 1'b0;
        end else begin
            ps2_armed <= 1'b1;
            ps2_copy  <= ps2_key[10];
        end
    end

    // PS/2 traffic wins; queued joystick events drain in any idle cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_strobe <= 1'b0;
            key_press  <= 1'b0;
            key_code   <= '0;
            rd_ptr     <= '0;
        end else begin
            key_strobe <= ps2_evt | ~empty;
            if (ps2_evt) begin
                key_press <= ps2_key[9];
                key_code  <= ps2_key[8:0];
            end else if (!empty) begin
                {key_press, key_code} <= mem[rd_ptr[AW-1:0]];
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_joy_keymap.sv
// Randomised + directed bench for joy_keymap against an event-level model:
// expected key events come from input diffs and the code table, not from timing.
module tb_joy_keymap;
    localparam int NJ = 2, NBT = 8, NB = NJ * NBT;

    logic        clk = 1'b0, reset_n = 1'b1;
    logic [NB-1:0] joy_in;
    logic [3:0]  cfg_mode;
    logic [1:0]  autofire_en;
    logic [10:0] ps2_key;
    logic        key_strobe, key_press, queue_full;
    logic [8:0]  key_code;

    logic [4:0]  af_joy;
    logic [1:0]  af_mode;
    logic        af_en;
    logic [10:0] af_ps2;
    logic        af_strobe, af_press, af_full;
    logic [8:0]  af_code;

    joy_keymap #(.NUM_JOY(NJ), .NUM_BTN(NBT), .FIFO_DEPTH(4), .AF_HALF(4)) u_dut (
        .clk(clk), .reset_n(reset_n), .joy_in(joy_in), .cfg_mode(cfg_mode),
        .autofire_en(autofire_en), .ps2_key(ps2_key), .key_strobe(key_strobe),
        .key_press(key_press), .key_code(key_code), .queue_full(queue_full));

    joy_keymap #(.NUM_JOY(1), .NUM_BTN(5), .FIFO_DEPTH(4), .AF_HALF(4)) u_af (
        .clk(clk), .reset_n(reset_n), .joy_in(af_joy), .cfg_mode(af_mode),
        .autofire_en(af_en), .ps2_key(af_ps2), .key_strobe(af_strobe),
        .key_press(af_press), .key_code(af_code), .queue_full(af_full));

    always #5 clk = ~clk;

    typedef struct { int c; logic [9:0] v; } ev_t;

    int         cyc = 0;
    int         checks = 0, errors = 0;
    ev_t        obs[$], obs_af[$], exp_ps2[$];
    logic [9:0] exp_joy[$];
    logic [NB-1:0] mr;
    logic [8:0] tab [4][8];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        ev_t e;
        e.c = cyc;
        if (key_strobe) begin e.v = {key_press, key_code}; obs.push_back(e); end
        if (af_strobe)  begin e.v = {af_press, af_code};   obs_af.push_back(e); end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // pm: 0 quiet, 1 random ps2 toggles, 2 ps2 toggle every cycle
    task automatic step(input int pm);
        ev_t e;
        logic p;
        logic [8:0] cd;
        @(posedge clk);
        #1;
        if (pm == 2 || (pm == 1 && $urandom_range(3) == 0)) begin
            p  = 1'($urandom_range(1));
            cd = 9'($urandom_range(511));
            ps2_key = {~ps2_key[10], p, cd};
            e.c = cyc + 1;
            e.v = {p, cd};
            exp_ps2.push_back(e);
        end
    endtask

    task automatic run(input int n, input int pm);
        repeat (n) step(pm);
    endtask

    task automatic apply(input logic [NB-1:0] nj, input logic [3:0] nm);
        int m;
        cfg_mode = nm;
        joy_in   = nj;
        for (int i = 0; i < NB; i++) begin
            if (nj[i] != mr[i]) begin
                m = int'(nm[2*(i/NBT) +: 2]);
                if (m != 0) exp_joy.push_back({nj[i], tab[m][i%NBT]});
                mr[i] = nj[i];
            end
        end
    endtask

    task automatic match(input bit lossy);
        ev_t o;
        int  k;
        while (obs.size() > 0) begin
            o = obs.pop_front();
            while (exp_ps2.size() > 0 && exp_ps2[0].c < o.c) begin
                chk("ps2_missed_cycle", o.c, exp_ps2[0].c);
                void'(exp_ps2.pop_front());
            end
            if (exp_ps2.size() > 0 && exp_ps2[0].c == o.c) begin
                chk("ps2_event", o.v, exp_ps2[0].v);
                void'(exp_ps2.pop_front());
            end else begin
                k = -1;
                foreach (exp_joy[i]) if (k < 0 && exp_joy[i] == o.v) k = i;
                if (k < 0) $display("FAIL joy_unexpected: got %0h", o.v);
                chk("joy_event_known", k >= 0, 1);
                if (k >= 0) exp_joy.delete(k);
            end
        end
        if (!lossy) begin
            chk("joy_left", exp_joy.size(), 0);
            chk("ps2_left", exp_ps2.size(), 0);
        end
        exp_joy.delete();
        exp_ps2.delete();
    endtask

    initial begin
        logic [9:0] want [3];
        logic [NB-1:0] nj;
        logic [3:0] nm;
        int t0, k, n;

        tab[0] = '{default: 9'h000};
        tab[1] = '{9'h03D, 9'h036, 9'h03E, 9'h046, 9'h045, 9'h03A, 9'h031, 9'h032};
        tab[2] = '{9'h01E, 9'h016, 9'h026, 9'h025, 9'h02E, 9'h01A, 9'h022, 9'h021};
        tab[3] = '{9'h174, 9'h16B, 9'h172, 9'h175, 9'h05A, 9'h00D, 9'h029, 9'h076};
        joy_in = '0; cfg_mode = '0; autofire_en = '0; ps2_key = '0; mr = '0;
        af_joy = '0; af_mode = 2'b01; af_en = 1'b0; af_ps2 = '0;

        #2 reset_n = 1'b0;
        #1;
        chk("rst_strobe", key_strobe, 0);
        chk("rst_press", key_press, 0);
        chk("rst_code", key_code, 0);
        chk("rst_full", queue_full, 0);
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        run(5, 0);

        // Sinclair1 fire press and release, with scan latency bound
        apply(16'h0010, 4'b0001);
        t0 = cyc;
        run(40, 0);
        chk("fire_cnt", obs.size(), 1);
        if (obs.size() > 0) begin
            chk("fire_make", obs[0].v, {1'b1, 9'h045});
            chk("fire_latency", (obs[0].c - t0) <= NB + 2, 1);
        end
        match(0);
        apply(16'h0000, 4'b0001);
        run(40, 0);
        if (obs.size() > 0) chk("fire_break", obs[0].v, {1'b0, 9'h045});
        match(0);

        // Cursor mode on channel 1, then channel 1 off
        apply(16'h0800, 4'b1101);
        run(40, 0);
        if (obs.size() > 0) chk("cursor_up", obs[0].v, {1'b1, 9'h175});
        match(0);
        apply(16'h0000, 4'b1101);
        run(40, 0);
        match(0);
        apply(16'h0800, 4'b0001);
        run(40, 0);
        chk("mode0_silent", obs.size(), 0);
        match(0);
        apply(16'h0000, 4'b0001);
        run(40, 0);
        match(0);

        // Three events held behind ps2 traffic, then drained in order
        run(1, 2);
        apply(16'h0010, 4'b0001); run(20, 2);
        apply(16'h0011, 4'b0001); run(20, 2);
        apply(16'h0019, 4'b0001); run(20, 2);
        begin
            ev_t e;
            @(posedge clk);
            #1;
            ps2_key = {~ps2_key[10], 1'b1, 9'h01C};
            e.c = cyc + 1; e.v = {1'b1, 9'h01C};
            exp_ps2.push_back(e);
            t0 = cyc + 1;
        end
        run(20, 0);
        want = '{{1'b1, 9'h045}, {1'b1, 9'h03D}, {1'b1, 9'h046}};
        k = -1;
        foreach (obs[i]) if (obs[i].c == t0) k = i;
        chk("order_ps2_found", k >= 0, 1);
        if (k >= 0) begin
            chk("order_ps2", obs[k].v, {1'b1, 9'h01C});
            for (int i = 1; i <= 3; i++) begin
                chk("order_avail", (k + i) < obs.size(), 1);
                if ((k + i) < obs.size()) begin
                    chk("order_val", obs[k+i].v, want[i-1]);
                    chk("order_cycle", obs[k+i].c, t0 + i);
                end
            end
        end
        match(0);
        apply(16'h0000, 4'b0001);
        run(40, 0);
        match(0);

        // Overflow: six changes into a depth-4 queue with no pop slots
        run(1, 2);
        apply(16'h003F, 4'b0001);
        run(40, 2);
        chk("overflow_full", queue_full, 1);
        run(60, 0);
        chk("overflow_drained", queue_full, 0);
        match(0);

        // Reset with queued events: nothing queued survives; held button re-reports
        run(1, 2);
        apply(16'h0020, 4'b0001);
        run(40, 2);
        match(1);
        #2 reset_n = 1'b0;
        #1;
        chk("midrst_strobe", key_strobe, 0);
        chk("midrst_press", key_press, 0);
        chk("midrst_code", key_code, 0);
        chk("midrst_full", queue_full, 0);
        mr = '0;
        joy_in = 16'h0004;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        apply(16'h0004, 4'b0001);
        run(60, 0);
        chk("held_cnt", obs.size(), 1);
        match(0);
        apply(16'h0000, 4'b0001);
        run(40, 0);
        match(0);

        // Random input changes, modes and ps2 traffic
        for (int it = 0; it < 25; it++) begin
            nj = joy_in;
            n = $urandom_range(4, 1);
            for (int r = 0; r < n; r++) nj[$urandom_range(NB-1)] ^= 1'b1;
            nm = ($urandom_range(2) == 0) ? 4'($urandom_range(15)) : cfg_mode;
            apply(nj, nm);
            run(110, 1);
            run(20, 0);
            match(0);
        end

        // Autofire: alternating make/break starting with make, final break
        obs_af.delete();
        af_en = 1'b1;
        af_joy = 5'b10000;
        run(40, 0);
        af_joy = 5'b00000;
        run(30, 0);
        chk("af_enough", obs_af.size() >= 3, 1);
        chk("af_even", obs_af.size() % 2, 0);
        foreach (obs_af[i]) begin
            chk("af_code", obs_af[i].v[8:0], 9'h045);
            chk("af_alt", obs_af[i].v[9], (i % 2) == 0);
        end
        obs_af.delete();
        af_en = 1'b0;
        af_joy = 5'b10000;
        run(40, 0);
        af_joy = 5'b00000;
        run(30, 0);
        chk("noaf_cnt", obs_af.size(), 2);
        if (obs_af.size() == 2) begin
            chk("noaf_make", obs_af[0].v, {1'b1, 9'h045});
            chk("noaf_break", obs_af[1].v, {1'b0, 9'h045});
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
